// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the out-of-order core front end:
//   - opcode-class constants carried on the *_type buses
//   - ROB_W, the ROB tag width
//   - rs_entry_t, one reservation-station slot
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int ROB_W = 5;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // One reservation-station slot. An operand value is meaningful only while
  // its qN_valid flag is low; otherwise the slot is waiting on tag qN.
  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] rob_id;
    logic [6:0]       typ;
    logic [3:0]       op;
    logic [31:0]      v1;
    logic             q1_valid;
    logic [ROB_W-1:0] q1;
    logic [31:0]      v2;
    logic             q2_valid;
    logic [ROB_W-1:0] q2;
  } rs_entry_t;

endpackage

// File: rtl/alu_rs_age_matrix.sv
// ---------------------------------------------------------------------------
// alu_rs_age_matrix
// Relative-age tracker for the ALU reservation station. Row i bit j set means
// entry i is older than entry j. Picks the oldest entry among a ready vector.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high clear of the matrix
//   en_i              state update enable (global ready)
//   alloc_valid_i/idx new entry becomes youngest
//   free_valid_i/idx  entry leaves; its row and column are cleared
//   valid_i           slots currently occupied (before this edge)
//   ready_i           slots eligible for issue this cycle
//   oldest_o          one-hot oldest ready slot (all zero when none ready)
// ---------------------------------------------------------------------------
module alu_rs_age_matrix #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             alloc_valid_i,
  input  logic [IDX_W-1:0] alloc_idx_i,
  input  logic             free_valid_i,
  input  logic [IDX_W-1:0] free_idx_i,
  input  logic [N-1:0]     valid_i,
  input  logic [N-1:0]     ready_i,
  output logic [N-1:0]     oldest_o
);

  logic [N-1:0][N-1:0] age_q;
  logic [N-1:0][N-1:0] age_d;

  // Allocation first, then free. The freed slot is always occupied and the
  // allocated one is always empty, so they never collide; any column bit the
  // allocation set on the freed row is wiped by the free.
  always_comb begin
    age_d = age_q;
    if (alloc_valid_i) begin
      age_d[alloc_idx_i] = '0;
      for (int r = 0; r < N; r++) begin
        if (valid_i[r]) age_d[r][alloc_idx_i] = 1'b1;
      end
    end
    if (free_valid_i) begin
      age_d[free_idx_i] = '0;
      for (int r = 0; r < N; r++) begin
        age_d[r][free_idx_i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      age_q <= '0;
    end else if (en_i) begin
      age_q <= age_d;
    end
  end

  // Slot i wins when it is ready and older than every other ready slot.
  always_comb begin
    oldest_o = '0;
    for (int i = 0; i < N; i++) begin
      oldest_o[i] = ready_i[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && ready_i[j] && !age_q[i][j]) oldest_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rs_scheduler
// Reservation station + issue scheduler in front of the single-cycle ALU.
// Holds up to RS_SIZE micro-ops, snoops the ALU and LSB CDBs for missing
// operands and issues the oldest fully-resolved entry, one per cycle.
// Optional build macro: ALU_RS_WAKEUP_BYPASS_EN -- when defined, operands
// broadcast on a CDB this cycle count as resolved and are forwarded straight
// into the issued operands (back-to-back dependent issue).
// Ports:
//   clk_in, rst_in, rdy_in, _clear       clock, sync reset, global ready, flush
//   _dp_*                                dispatch request and micro-op fields
//   _rs_full                             no free slot (from current state)
//   _cdb_alu_*, _cdb_lsb_*               result broadcasts
//   _alu_*                               issue strobe and issued fields
// ROB_W must match cpu_pkg::ROB_W (the slot struct is sized by the package).
// ---------------------------------------------------------------------------
module alu_rs_scheduler #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = cpu_pkg::ROB_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             _clear,
  input  logic             _dp_valid,
  input  logic [ROB_W-1:0] _dp_rob_id,
  input  logic [6:0]       _dp_type,
  input  logic [3:0]       _dp_op,
  input  logic [31:0]      _dp_v1,
  input  logic [31:0]      _dp_v2,
  input  logic             _dp_q1_valid,
  input  logic             _dp_q2_valid,
  input  logic [ROB_W-1:0] _dp_q1,
  input  logic [ROB_W-1:0] _dp_q2,
  output logic             _rs_full,
  input  logic             _cdb_alu_ready,
  input  logic             _cdb_lsb_ready,
  input  logic [ROB_W-1:0] _cdb_alu_rob_id,
  input  logic [ROB_W-1:0] _cdb_lsb_rob_id,
  input  logic [31:0]      _cdb_alu_value,
  input  logic [31:0]      _cdb_lsb_value,
  output logic             _alu_ready,
  output logic [ROB_W-1:0] _alu_rob_id,
  output logic [6:0]       _alu_type,
  output logic [3:0]       _alu_op,
  output logic [31:0]      _alu_v1,
  output logic [31:0]      _alu_v2
);

  localparam int IDX_W = $clog2(RS_SIZE);

  typedef cpu_pkg::rs_entry_t entry_t;

  entry_t entries_q [RS_SIZE];
  entry_t entries_d [RS_SIZE];
  entry_t woken     [RS_SIZE];
  entry_t dp_entry;
  entry_t sel_entry;

  logic [RS_SIZE-1:0] valid_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [RS_SIZE-1:0] oldest_oh;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   alloc_idx;
  logic               issue_fire;
  logic               dp_fire;
  logic               flush;

  // Apply this cycle's CDB broadcasts to one slot. ALU CDB is checked first
  // so it wins if both buses (erroneously) carry the same tag.
  function automatic entry_t snoop(input entry_t e,
                                   input logic a_rdy, input logic [ROB_W-1:0] a_id,
                                   input logic [31:0] a_val,
                                   input logic l_rdy, input logic [ROB_W-1:0] l_id,
                                   input logic [31:0] l_val);
    entry_t r;
    r = e;
    if (r.valid && r.q1_valid) begin
      if (a_rdy && r.q1 == a_id) begin
        r.v1 = a_val;
        r.q1_valid = 1'b0;
      end else if (l_rdy && r.q1 == l_id) begin
        r.v1 = l_val;
        r.q1_valid = 1'b0;
      end
    end
    if (r.valid && r.q2_valid) begin
      if (a_rdy && r.q2 == a_id) begin
        r.v2 = a_val;
        r.q2_valid = 1'b0;
      end else if (l_rdy && r.q2 == l_id) begin
        r.v2 = l_val;
        r.q2_valid = 1'b0;
      end
    end
    return r;
  endfunction

  assign flush = rst_in | _clear;

  // Incoming micro-op and the post-wakeup view of every stored slot.
  always_comb begin
    dp_entry          = '0;
    dp_entry.valid    = 1'b1;
    dp_entry.rob_id   = _dp_rob_id;
    dp_entry.typ      = _dp_type;
    dp_entry.op       = _dp_op;
    dp_entry.v1       = _dp_v1;
    dp_entry.q1_valid = _dp_q1_valid;
    dp_entry.q1       = _dp_q1;
    dp_entry.v2       = _dp_v2;
    dp_entry.q2_valid = _dp_q2_valid;
    dp_entry.q2       = _dp_q2;
    for (int i = 0; i < RS_SIZE; i++) begin
      woken[i] = snoop(entries_q[i], _cdb_alu_ready, _cdb_alu_rob_id, _cdb_alu_value,
                       _cdb_lsb_ready, _cdb_lsb_rob_id, _cdb_lsb_value);
    end
  end

  // Occupancy and issue eligibility per slot.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_vec[i] = entries_q[i].valid;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
      ready_vec[i] = woken[i].valid & ~woken[i].q1_valid & ~woken[i].q2_valid;
`else
      ready_vec[i] = entries_q[i].valid & ~entries_q[i].q1_valid & ~entries_q[i].q2_valid;
`endif
    end
  end

  // Lowest-index free slot (scan downward so the lowest one sticks) and the
  // index of the one-hot oldest ready slot.
  always_comb begin
    alloc_idx = '0;
    sel_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_idx = IDX_W'(i);
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (oldest_oh[i]) sel_idx = IDX_W'(i);
    end
  end

  assign _rs_full   = &valid_vec;
  assign issue_fire = (|ready_vec) & rdy_in & ~flush;
  assign dp_fire    = _dp_valid & ~_rs_full & rdy_in & ~flush;

`ifdef ALU_RS_WAKEUP_BYPASS_EN
  assign sel_entry = woken[sel_idx];
`else
  assign sel_entry = entries_q[sel_idx];
`endif

  // Next state: wakeup everywhere, free the issued slot, then allocate.
  // Allocation uses a slot that was empty before this edge, so a slot freed
  // by this cycle's issue is not reused until the next cycle.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_d[i] = rdy_in ? woken[i] : entries_q[i];
    end
    if (issue_fire) entries_d[sel_idx].valid = 1'b0;
    if (dp_fire) begin
      entries_d[alloc_idx] = snoop(dp_entry, _cdb_alu_ready, _cdb_alu_rob_id, _cdb_alu_value,
                                   _cdb_lsb_ready, _cdb_lsb_rob_id, _cdb_lsb_value);
    end
  end

  always_ff @(posedge clk_in) begin
    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= entries_d[i];
    end
  end

  // Issue port: fields of the selected slot, all zero when nothing issues.
  always_comb begin
    _alu_ready  = issue_fire;
    _alu_rob_id = '0;
    _alu_type   = '0;
    _alu_op     = '0;
    _alu_v1     = '0;
    _alu_v2     = '0;
    if (issue_fire) begin
      _alu_rob_id = sel_entry.rob_id;
      _alu_type   = sel_entry.typ;
      _alu_op     = sel_entry.op;
      _alu_v1     = sel_entry.v1;
      _alu_v2     = sel_entry.v2;
    end
  end

  alu_rs_age_matrix #(
    .N     (RS_SIZE),
    .IDX_W (IDX_W)
  ) u_age (
    .clk_i         (clk_in),
    .rst_i         (flush),
    .en_i          (rdy_in),
    .alloc_valid_i (dp_fire),
    .alloc_idx_i   (alloc_idx),
    .free_valid_i  (issue_fire),
    .free_idx_i    (sel_idx),
    .valid_i       (valid_vec),
    .ready_i       (ready_vec),
    .oldest_o      (oldest_oh)
  );

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rs_scheduler
// Directed bench for alu_rs_scheduler. A queue-based model (entries kept in
// dispatch order, so the queue order is the age order) predicts the issue
// port and _rs_full every cycle; directed checks pin key cycles by hand.
// Honours ALU_RS_WAKEUP_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_alu_rs_scheduler;

  localparam int RS_SIZE = 8;
  localparam int ROB_W   = 5;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, _clear;
  logic             _dp_valid;
  logic [ROB_W-1:0] _dp_rob_id;
  logic [6:0]       _dp_type;
  logic [3:0]       _dp_op;
  logic [31:0]      _dp_v1, _dp_v2;
  logic             _dp_q1_valid, _dp_q2_valid;
  logic [ROB_W-1:0] _dp_q1, _dp_q2;
  logic             _rs_full;
  logic             _cdb_alu_ready, _cdb_lsb_ready;
  logic [ROB_W-1:0] _cdb_alu_rob_id, _cdb_lsb_rob_id;
  logic [31:0]      _cdb_alu_value, _cdb_lsb_value;
  logic             _alu_ready;
  logic [ROB_W-1:0] _alu_rob_id;
  logic [6:0]       _alu_type;
  logic [3:0]       _alu_op;
  logic [31:0]      _alu_v1, _alu_v2;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct packed {
    logic             rst, clr, rdy, dpv;
    logic [ROB_W-1:0] rob;
    logic [6:0]       typ;
    logic [3:0]       op;
    logic [31:0]      v1;
    logic             p1;
    logic [ROB_W-1:0] q1;
    logic [31:0]      v2;
    logic             p2;
    logic [ROB_W-1:0] q2;
    logic             av;
    logic [ROB_W-1:0] aid;
    logic [31:0]      aval;
    logic             lv;
    logic [ROB_W-1:0] lid;
    logic [31:0]      lval;
  } stim_t;

  typedef struct {
    logic [ROB_W-1:0] rob;
    logic [6:0]       typ;
    logic [3:0]       op;
    logic [31:0]      v1, v2;
    logic             p1, p2;
    logic [ROB_W-1:0] q1, q2;
  } mop_t;

  mop_t rs[$];
  bit   modelValid = 1'b0;

  alu_rs_scheduler #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
    ._dp_valid(_dp_valid), ._dp_rob_id(_dp_rob_id), ._dp_type(_dp_type), ._dp_op(_dp_op),
    ._dp_v1(_dp_v1), ._dp_v2(_dp_v2), ._dp_q1_valid(_dp_q1_valid), ._dp_q2_valid(_dp_q2_valid),
    ._dp_q1(_dp_q1), ._dp_q2(_dp_q2), ._rs_full(_rs_full),
    ._cdb_alu_ready(_cdb_alu_ready), ._cdb_lsb_ready(_cdb_lsb_ready),
    ._cdb_alu_rob_id(_cdb_alu_rob_id), ._cdb_lsb_rob_id(_cdb_lsb_rob_id),
    ._cdb_alu_value(_cdb_alu_value), ._cdb_lsb_value(_cdb_lsb_value),
    ._alu_ready(_alu_ready), ._alu_rob_id(_alu_rob_id), ._alu_type(_alu_type),
    ._alu_op(_alu_op), ._alu_v1(_alu_v1), ._alu_v2(_alu_v2)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk_in = ~clk_in;

  // Resolve a model entry's pending operands against the CDBs currently driven.
  function automatic mop_t snoopM(input mop_t m);
    mop_t r;
    r = m;
    if (r.p1 && _cdb_alu_ready && r.q1 == _cdb_alu_rob_id) begin r.v1 = _cdb_alu_value; r.p1 = 1'b0; end
    else if (r.p1 && _cdb_lsb_ready && r.q1 == _cdb_lsb_rob_id) begin r.v1 = _cdb_lsb_value; r.p1 = 1'b0; end
    if (r.p2 && _cdb_alu_ready && r.q2 == _cdb_alu_rob_id) begin r.v2 = _cdb_alu_value; r.p2 = 1'b0; end
    else if (r.p2 && _cdb_lsb_ready && r.q2 == _cdb_lsb_rob_id) begin r.v2 = _cdb_lsb_value; r.p2 = 1'b0; end
    return r;
  endfunction

  // Every falling edge: predict this cycle's outputs from the model, compare,
  // then advance the model to the state after the coming rising edge.
  always @(negedge clk_in) begin
    logic [80:0] expIssue;
    logic [80:0] actIssue;
    int          issueIdx;
    bit          wasFull;
    mop_t        m;
    mop_t        dp;
    issueIdx = -1;
    expIssue = '0;
    if (!rst_in && !_clear && rdy_in) begin
      for (int k = 0; k < rs.size(); k++) begin
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        m = snoopM(rs[k]);
`else
        m = rs[k];
`endif
        if (issueIdx < 0 && !m.p1 && !m.p2) begin
          issueIdx = k;
          expIssue = {1'b1, m.rob, m.typ, m.op, m.v1, m.v2};
        end
      end
    end
    wasFull = (rs.size() == RS_SIZE);
    if (modelValid) begin
      actIssue = {_alu_ready, _alu_rob_id, _alu_type, _alu_op, _alu_v1, _alu_v2};
      vecCount++;
      if (actIssue !== expIssue) begin
        missCount++;
        $display("[TB] FAIL issue_port @%0t: got %h expected %h", $time, actIssue, expIssue);
      end
      vecCount++;
      if (_rs_full !== wasFull) begin
        missCount++;
        $display("[TB] FAIL rs_full @%0t: got %b expected %b", $time, _rs_full, wasFull);
      end
    end
    if (rst_in || _clear) begin
      rs.delete();
    end else if (rdy_in) begin
      if (issueIdx >= 0) rs.delete(issueIdx);
      for (int k = 0; k < rs.size(); k++) rs[k] = snoopM(rs[k]);
      if (_dp_valid && !wasFull) begin
        dp = '{_dp_rob_id, _dp_type, _dp_op, _dp_v1, _dp_v2, _dp_q1_valid, _dp_q2_valid, _dp_q1, _dp_q2};
        rs.push_back(snoopM(dp));
      end
    end
    if (rst_in) modelValid = 1'b1;
  end

  function automatic stim_t idleS();
    stim_t s;
    s = '0;
    s.rdy = 1'b1;
    return s;
  endfunction

  function automatic stim_t dispS(input logic [ROB_W-1:0] rob, input logic [6:0] typ,
                                  input logic [3:0] op, input logic [31:0] v1, input logic p1,
                                  input logic [ROB_W-1:0] q1, input logic [31:0] v2,
                                  input logic p2, input logic [ROB_W-1:0] q2);
    stim_t s;
    s = idleS();
    s.dpv = 1'b1; s.rob = rob; s.typ = typ; s.op = op;
    s.v1 = v1; s.p1 = p1; s.q1 = q1; s.v2 = v2; s.p2 = p2; s.q2 = q2;
    return s;
  endfunction

  // Drive one cycle's inputs just after the rising edge and return just after
  // the falling edge, when this cycle's outputs are settled.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk_in);
    #1;
    rst_in = s.rst; _clear = s.clr; rdy_in = s.rdy; _dp_valid = s.dpv;
    _dp_rob_id = s.rob; _dp_type = s.typ; _dp_op = s.op;
    _dp_v1 = s.v1; _dp_q1_valid = s.p1; _dp_q1 = s.q1;
    _dp_v2 = s.v2; _dp_q2_valid = s.p2; _dp_q2 = s.q2;
    _cdb_alu_ready = s.av; _cdb_alu_rob_id = s.aid; _cdb_alu_value = s.aval;
    _cdb_lsb_ready = s.lv; _cdb_lsb_rob_id = s.lid; _cdb_lsb_value = s.lval;
    @(negedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Directed sequence with hand-computed checkpoints.
  initial begin
    stim_t s;
    s = idleS();
    s.rst = 1'b1;
    rst_in = 1'b1; _clear = 1'b0; rdy_in = 1'b1; _dp_valid = 1'b0;
    _dp_rob_id = '0; _dp_type = '0; _dp_op = '0; _dp_v1 = '0; _dp_v2 = '0;
    _dp_q1_valid = 1'b0; _dp_q2_valid = 1'b0; _dp_q1 = '0; _dp_q2 = '0;
    _cdb_alu_ready = 1'b0; _cdb_lsb_ready = 1'b0; _cdb_alu_rob_id = '0; _cdb_lsb_rob_id = '0;
    _cdb_alu_value = '0; _cdb_lsb_value = '0;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idleS());
    checkOutput("reset_alu_ready", _alu_ready, 0);
    checkOutput("reset_rs_full", _rs_full, 0);

    // Independent ADD issues the cycle after dispatch.
    applyStimulus(dispS(3, cpu_pkg::OPC_R, 4'd0, 32'd5, 1'b0, 0, 32'd7, 1'b0, 0));
    checkOutput("add_not_same_cycle", _alu_ready, 0);
    applyStimulus(idleS());
    checkOutput("add_ready", _alu_ready, 1);
    checkOutput("add_rob", _alu_rob_id, 3);
    checkOutput("add_v1", _alu_v1, 5);
    checkOutput("add_v2", _alu_v2, 7);
    checkOutput("add_full", _rs_full, 0);
    applyStimulus(idleS());
    checkOutput("add_freed", _alu_ready, 0);

    // Operand 1 waits on tag 2, broadcast on the ALU CDB two cycles later.
    applyStimulus(dispS(4, cpu_pkg::OPC_I, 4'd1, 32'd0, 1'b1, 2, 32'd3, 1'b0, 0));
    applyStimulus(idleS());
    checkOutput("wait_not_ready", _alu_ready, 0);
    s = idleS(); s.av = 1'b1; s.aid = 2; s.aval = 32'h10;
    applyStimulus(s);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    checkOutput("bypass_ready", _alu_ready, 1);
    checkOutput("bypass_v1", _alu_v1, 32'h10);
    applyStimulus(idleS());
    checkOutput("bypass_done", _alu_ready, 0);
`else
    checkOutput("wake_cdb_cycle", _alu_ready, 0);
    applyStimulus(idleS());
    checkOutput("wake_ready", _alu_ready, 1);
    checkOutput("wake_rob", _alu_rob_id, 4);
    checkOutput("wake_v1", _alu_v1, 32'h10);
`endif
    applyStimulus(idleS());

    // Fill every slot behind tag 9, try one more, then release on the LSB CDB.
    for (int k = 0; k < RS_SIZE; k++)
      applyStimulus(dispS(ROB_W'(10 + k), cpu_pkg::OPC_R, 4'(k), 32'd0, 1'b1, 9, 32'(k), 1'b0, 0));
    applyStimulus(dispS(20, cpu_pkg::OPC_R, 4'd0, 32'd0, 1'b1, 9, 32'd0, 1'b0, 0));
    checkOutput("fill_full", _rs_full, 1);
    checkOutput("fill_no_issue", _alu_ready, 0);
    $display("[TB] note: dispatch while full was driven deliberately; it must be dropped");
    s = idleS(); s.lv = 1'b1; s.lid = 9; s.lval = 32'h99;
    applyStimulus(s);
    checkOutput("release_full", _rs_full, 1);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    checkOutput("release_rob_0", _alu_rob_id, 10);
    for (int k = 1; k < RS_SIZE; k++) begin
`else
    checkOutput("release_cdb_cycle", _alu_ready, 0);
    for (int k = 0; k < RS_SIZE; k++) begin
`endif
      applyStimulus(idleS());
      checkOutput($sformatf("release_rob_%0d", k), _alu_rob_id, 32'(10 + k));
      checkOutput($sformatf("release_v1_%0d", k), _alu_v1, 32'h99);
    end
    applyStimulus(idleS());
    checkOutput("release_drained", _alu_ready, 0);
    checkOutput("release_empty", _rs_full, 0);

    // Dispatch catches a same-cycle LSB broadcast of its second operand.
    s = dispS(5, cpu_pkg::OPC_B, 4'd2, 32'd1, 1'b0, 0, 32'd0, 1'b1, 6);
    s.lv = 1'b1; s.lid = 6; s.lval = 32'hABCD;
    applyStimulus(s);
    applyStimulus(idleS());
    checkOutput("catch_ready", _alu_ready, 1);
    checkOutput("catch_rob", _alu_rob_id, 5);
    checkOutput("catch_v2", _alu_v2, 32'hABCD);
    checkOutput("catch_type", _alu_type, 32'(cpu_pkg::OPC_B));

    // Three entries woken together, then flushed.
    for (int k = 0; k < 3; k++)
      applyStimulus(dispS(ROB_W'(21 + k), cpu_pkg::OPC_JAL, 4'd0, 32'd0, 1'b1, 30, 32'd4, 1'b0, 0));
    s = idleS(); s.av = 1'b1; s.aid = 30; s.aval = 32'h5;
    applyStimulus(s);
    s = idleS(); s.clr = 1'b1;
    applyStimulus(s);
    checkOutput("clear_no_issue", _alu_ready, 0);
    applyStimulus(idleS());
    checkOutput("after_clear_issue", _alu_ready, 0);
    checkOutput("after_clear_full", _rs_full, 0);

    // rdy_in low freezes a ready entry and ignores dispatch/CDB inputs.
    applyStimulus(dispS(7, cpu_pkg::OPC_AUIPC, 4'd3, 32'h11, 1'b0, 0, 32'h22, 1'b0, 0));
    for (int k = 0; k < 3; k++) begin
      s = dispS(8, cpu_pkg::OPC_R, 4'd0, 32'd1, 1'b0, 0, 32'd2, 1'b0, 0);
      s.rdy = 1'b0; s.lv = 1'b1; s.lid = 7; s.lval = 32'hDEAD;
      applyStimulus(s);
      checkOutput($sformatf("frozen_%0d", k), _alu_ready, 0);
    end
    applyStimulus(dispS(9, cpu_pkg::OPC_JALR, 4'd5, 32'h33, 1'b0, 0, 32'h44, 1'b0, 0));
    checkOutput("thaw_ready", _alu_ready, 1);
    checkOutput("thaw_rob", _alu_rob_id, 7);
    checkOutput("thaw_v1", _alu_v1, 32'h11);
    applyStimulus(idleS());
    checkOutput("next_rob", _alu_rob_id, 9);
    checkOutput("next_op", _alu_op, 5);
    applyStimulus(idleS());
    checkOutput("final_idle", _alu_ready, 0);
    applyStimulus(idleS());

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
- Reservation station and issue scheduler in front of the single-cycle ALU.
- Holds up to RS_SIZE dispatched ALU/branch/jump/AUIPC micro-ops and snoops the two CDBs (ALU, LSB) for missing operands.
- Each cycle, issues the oldest entry whose operands are both resolved to the ALU; at most one issue per cycle.
- Sits between dispatch/ROB rename and the ALU. Dispatch stalls on _rs_full.

Parameters:
- RS_SIZE, 8, number of entries (power of two, 2..16)
- ROB_W, 5, ROB tag width

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; state frozen when low
- _clear  input  1  misprediction flush; synchronous
- _dp_valid  input  1  dispatch request
- _dp_rob_id  input  ROB_W  destination ROB tag
- _dp_type  input  7  opcode class (0110011/0010011/1100011/1101111/1100111/0010111)
- _dp_op  input  4  ALU op code
- _dp_v1, _dp_v2  input  32  operand values (valid when matching q_valid low)
- _dp_q1_valid, _dp_q2_valid  input  1  operand pending on a ROB tag
- _dp_q1, _dp_q2  input  ROB_W  producer tags
- _rs_full  output  1  no free entry
- _cdb_alu_ready, _cdb_lsb_ready  input  1  CDB broadcast valid
- _cdb_alu_rob_id, _cdb_lsb_rob_id  input  ROB_W  broadcast tag
- _cdb_alu_value, _cdb_lsb_value  input  32  broadcast value
- _alu_ready  output  1  issue strobe to ALU
- _alu_rob_id  output  ROB_W  issued tag
- _alu_type  output  7  issued type
- _alu_op  output  4  issued op
- _alu_v1, _alu_v2  output  32  issued operands

Behaviour:
- Single clock clk_in; rst_in is synchronous, active-high.
- Reset or _clear, evaluated at the edge: all entries invalid, age matrix cleared. _rs_full is 0 after reset. _alu_ready is forced 0 in any cycle where rst_in or _clear is high.
- rdy_in low: no state update, _alu_ready forced 0. Dispatch and CDB inputs in that cycle are ignored; producers hold them.
- Entry fields:
  - valid, rob_id, type, op
  - v1/q1_valid/q1 and v2/q2_valid/q2
  - ready = valid & !q1_valid & !q2_valid, from registered state only.
- Issue is combinational from current state:
  - _alu_ready = any ready entry.
  - Selected = oldest ready entry per age matrix.
  - Outputs carry its fields; all-zero when _alu_ready=0.
  - Entry is freed at the same edge. ALU captures the same edge and broadcasts on the CDB next cycle. Dispatch-to-issue minimum latency is 1 cycle.
- Dispatch (_dp_valid & !_rs_full & rdy_in): write to the lowest-index invalid entry and mark it youngest in the age matrix.
- Dispatch while _rs_full: dropped. Dispatcher must not do this; the bench asserts on it.
- _rs_full = (valid count == RS_SIZE), from current state. An issue in the same cycle does not unblock dispatch until next cycle.
- Wakeup, per edge:
  - Every valid entry with qN_valid and qN == a valid CDB tag takes that CDB's value and clears qN_valid.
  - A dispatching op whose _dp_qN matches a same-cycle CDB tag captures the value at allocation. No missed wakeup.
  - If both CDBs match the same tag (protocol error), the ALU CDB wins.
- An entry issued and woken in the same cycle: issue wins (already ready, no pending tags).
- Same-cycle issue + dispatch: both occur. The freed slot is not reusable until next cycle.
- Age matrix: row i bit j set = i older than j. Allocation sets the new row to 0 and column bits of valid rows to 1. Freeing clears the row/column.

Optional Feature:
- Macro: ALU_RS_WAKEUP_BYPASS_EN.
- Defined: readiness also counts operands matched by this cycle's CDB broadcasts. The issued value is muxed from the CDB, giving back-to-back dependent issue (ALU result at cycle N, dependent issues at cycle N).
- Undefined: readiness from registered state only; a dependent issues ≥1 cycle after the producer's CDB cycle.

Decomposition:
- Shared package (cpu_pkg): opcode-class constants (OPC_R=0110011, OPC_I=0010011, OPC_B=1100011, OPC_JAL, OPC_JALR, OPC_AUIPC), ROB_W, and the rs_entry_t struct.
- One sub-module: alu_rs_age_matrix (alloc index, free index, ready vector in; oldest-ready one-hot out).

Test Plan:
- Dispatch ADD rob=3, v1=5, v2=7, no pending tags -> next cycle _alu_ready=1, rob_id=3, v1=5, v2=7; entry freed; _rs_full=0.
- Dispatch rob=4 with q1=2 pending; CDB ALU broadcasts tag 2 value 0x10 two cycles later -> issue one cycle after broadcast (bypass off) or the same cycle (bypass on) with v1=0x10.
- Fill 8 entries all waiting on tag 9 -> _rs_full=1; further _dp_valid dropped. Broadcast tag 9 on LSB CDB -> entries issue oldest-first, one per cycle, rob order preserved across 8 cycles.
- Dispatch with q2=6 in the same cycle that CDB LSB broadcasts tag 6 value 0xABCD -> entry stored with v2=0xABCD and issues next cycle.
- Three entries ready, pulse _clear -> _alu_ready=0 that cycle; all entries invalid; no issue afterwards; _rs_full=0.
- Hold rdy_in low with a ready entry -> _alu_ready=0, state held. Release -> entry issues in the first rdy_in-high cycle.
